// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge completion path.
// Holds the tag width, the drain watchdog default, the per-tag completion
// entry layout and the completion scheduler state encoding.
package apb2axi_pkg;

    localparam int TAG_W     = 4;
    localparam int DRAIN_TMO = 1024;

    // One completion as recorded per tag and later shown to the gateway.
    typedef struct packed {
        logic       error;
        logic [1:0] resp;
        logic [7:0] num_beats;
        logic       is_write;
    } cpl_entry_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PRESENT = 2'd2,
        S_DRAIN   = 2'd3
    } cpl_sched_state_e;

endpackage

// File: rtl/apb2axi_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting at
// 'start' (inclusive) and wrapping, returns the first requesting index.
module apb2axi_rr_pick #(
    parameter int TAG_W = 4
) (
    input  logic [2**TAG_W-1:0] req,
    input  logic [TAG_W-1:0]    start,
    output logic                found,
    output logic [TAG_W-1:0]    idx
);

    localparam int NUM_TAGS = 2**TAG_W;

    // First set request at or after start, wrapping through the top index.
    always_comb begin
        logic [TAG_W-1:0] cand;
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < NUM_TAGS; i++) begin
            cand = start + TAG_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/apb2axi_cpl_sched.sv
// Completion scheduler between the AXI response handler and the APB
// register gateway. Completions are recorded per tag; one at a time is
// presented on rd_status_* in round-robin order. After a read completion is
// consumed the next status is held off until its RD_DATA stream has drained.
// Optional feature: define APB2AXI_CPL_TIMEOUT_EN to enable a drain watchdog
// of DRAIN_TMO cycles without a beat.
module apb2axi_cpl_sched
    import apb2axi_pkg::*;
#(
    parameter int TAG_W     = apb2axi_pkg::TAG_W,
    parameter int DRAIN_TMO = apb2axi_pkg::DRAIN_TMO
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic             cpl_error,
    input  logic [1:0]       cpl_resp,
    input  logic [7:0]       cpl_num_beats,
    input  logic             cpl_is_write,
    output logic             rd_status_valid,
    output logic             rd_status_error,
    output logic [1:0]       rd_status_resp,
    output logic [TAG_W-1:0] rd_status_tag,
    output logic [7:0]       rd_status_num_beats,
    output logic             rd_status_is_write,
    input  logic             dir_consumed_valid,
    input  logic [TAG_W-1:0] dir_consumed_tag,
    input  logic             rdf_beat,
    input  logic             rdf_last,
    output logic [TAG_W:0]   pending_cnt,
    output logic             consume_err,
    output logic             drain_err
);

    localparam int NUM_TAGS = 2**TAG_W;

    cpl_sched_state_e    state_q, state_d;
    logic [NUM_TAGS-1:0] pend_q, pend_d;
    cpl_entry_t          tbl_q [NUM_TAGS];
    cpl_entry_t          tbl_d [NUM_TAGS];
    logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]    pick_q, pick_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;
    logic                rd_valid_q, rd_valid_d;
    cpl_entry_t          rd_ent_q, rd_ent_d;
    logic [TAG_W-1:0]    rd_tag_q, rd_tag_d;
    logic [TAG_W:0]      pending_cnt_q, pending_cnt_d;
    logic                consume_err_q, consume_err_d;
    logic                drain_err_q, drain_err_d;

    logic                pick_found_s;
    logic [TAG_W-1:0]    pick_idx_s;
    logic                consume_hit_s;
    logic [8:0]          beat_next_s;
    logic [8:0]          beats_total_s;

`ifdef APB2AXI_CPL_TIMEOUT_EN
    localparam int TMO_W = $clog2(DRAIN_TMO + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    localparam int unused_drain_tmo = DRAIN_TMO;
`endif

    function automatic logic [TAG_W:0] pop_count(input logic [NUM_TAGS-1:0] v);
        logic [TAG_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            c = c + {{TAG_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    apb2axi_rr_pick #(
        .TAG_W (TAG_W)
    ) u_rr_pick (
        .req   (pend_q),
        .start (rr_ptr_q),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state for the FSM, the tag table and the sticky error flags.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        tbl_d         = tbl_q;
        rr_ptr_d      = rr_ptr_q;
        pick_d        = pick_q;
        beat_cnt_d    = beat_cnt_q;
        rd_valid_d    = rd_valid_q;
        rd_ent_d      = rd_ent_q;
        rd_tag_d      = rd_tag_q;
        consume_err_d = consume_err_q;
        drain_err_d   = drain_err_q;
`ifdef APB2AXI_CPL_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif
        beat_next_s   = beat_cnt_q + 9'd1;
        beats_total_s = {1'b0, rd_ent_q.num_beats} + 9'd1;
        consume_hit_s = dir_consumed_valid && (state_q == S_PRESENT) &&
                        (dir_consumed_tag == rd_tag_q);

        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    pick_d  = pick_idx_s;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                rd_ent_d   = tbl_q[pick_q];
                rd_tag_d   = pick_q;
                rd_valid_d = 1'b1;
                state_d    = S_PRESENT;
            end
            S_PRESENT: begin
                if (consume_hit_s) begin
                    pend_d[rd_tag_q] = 1'b0;
                    rr_ptr_d         = rd_tag_q + TAG_W'(1);
                    rd_valid_d       = 1'b0;
                    beat_cnt_d       = 9'd0;
`ifdef APB2AXI_CPL_TIMEOUT_EN
                    tmo_d            = '0;
`endif
                    state_d          = rd_ent_q.is_write ? S_IDLE : S_DRAIN;
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_DRAIN: begin
                if (rdf_beat) begin
                    beat_cnt_d = beat_next_s;
`ifdef APB2AXI_CPL_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                    if (rdf_last) begin
                        // Last beat ends the drain; flag a short or long burst.
                        if (beat_next_s != beats_total_s) begin
                            drain_err_d = 1'b1;
                        end else begin
                            drain_err_d = drain_err_q;
                        end
                        state_d = S_IDLE;
                    end else if (beat_next_s == beats_total_s) begin
                        // All expected beats seen but no last marker.
                        drain_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
`ifdef APB2AXI_CPL_TIMEOUT_EN
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_d == TMO_W'(DRAIN_TMO)) begin
                        drain_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
`else
                    state_d = S_DRAIN;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (dir_consumed_valid && !consume_hit_s) begin
            consume_err_d = 1'b1;
        end else begin
            consume_err_d = consume_err_d;
        end

        // Applied after the consume so a same-cycle completion keeps the tag pending.
        if (cpl_valid) begin
            pend_d[cpl_tag]          = 1'b1;
            tbl_d[cpl_tag].error     = cpl_error;
            tbl_d[cpl_tag].resp      = cpl_resp;
            tbl_d[cpl_tag].num_beats = cpl_num_beats;
            tbl_d[cpl_tag].is_write  = cpl_is_write;
        end else begin
            pend_d = pend_d;
        end

        pending_cnt_d = pop_count(pend_q);
    end

    // State, table and output registers with asynchronous reset.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            tbl_q         <= '{default: '0};
            rr_ptr_q      <= '0;
            pick_q        <= '0;
            beat_cnt_q    <= 9'd0;
            rd_valid_q    <= 1'b0;
            rd_ent_q      <= '0;
            rd_tag_q      <= '0;
            pending_cnt_q <= '0;
            consume_err_q <= 1'b0;
            drain_err_q   <= 1'b0;
`ifdef APB2AXI_CPL_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            tbl_q         <= tbl_d;
            rr_ptr_q      <= rr_ptr_d;
            pick_q        <= pick_d;
            beat_cnt_q    <= beat_cnt_d;
            rd_valid_q    <= rd_valid_d;
            rd_ent_q      <= rd_ent_d;
            rd_tag_q      <= rd_tag_d;
            pending_cnt_q <= pending_cnt_d;
            consume_err_q <= consume_err_d;
            drain_err_q   <= drain_err_d;
`ifdef APB2AXI_CPL_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign rd_status_valid     = rd_valid_q;
    assign rd_status_error     = rd_ent_q.error;
    assign rd_status_resp      = rd_ent_q.resp;
    assign rd_status_tag       = rd_tag_q;
    assign rd_status_num_beats = rd_ent_q.num_beats;
    assign rd_status_is_write  = rd_ent_q.is_write;
    assign pending_cnt         = pending_cnt_q;
    assign consume_err         = consume_err_q;
    assign drain_err           = drain_err_q;

endmodule

// File: tb/tb_apb2axi_cpl_sched.sv
// Self-checking bench for apb2axi_cpl_sched: expected presentations are
// queued as stimulus is issued and a monitor compares each new status.
`timescale 1ns/1ps
module tb_apb2axi_cpl_sched;

    localparam int TW = 4;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cpl_valid, cpl_error, cpl_is_write;
    logic [TW-1:0] cpl_tag;
    logic [1:0]    cpl_resp;
    logic [7:0]    cpl_num_beats;
    logic          rd_status_valid, rd_status_error, rd_status_is_write;
    logic [1:0]    rd_status_resp;
    logic [TW-1:0] rd_status_tag;
    logic [7:0]    rd_status_num_beats;
    logic          dir_consumed_valid;
    logic [TW-1:0] dir_consumed_tag;
    logic          rdf_beat, rdf_last;
    logic [TW:0]   pending_cnt;
    logic          consume_err, drain_err;

    apb2axi_cpl_sched #(.TAG_W(TW), .DRAIN_TMO(16)) dut (
        .pclk(pclk), .preset(preset),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_error(cpl_error),
        .cpl_resp(cpl_resp), .cpl_num_beats(cpl_num_beats), .cpl_is_write(cpl_is_write),
        .rd_status_valid(rd_status_valid), .rd_status_error(rd_status_error),
        .rd_status_resp(rd_status_resp), .rd_status_tag(rd_status_tag),
        .rd_status_num_beats(rd_status_num_beats), .rd_status_is_write(rd_status_is_write),
        .dir_consumed_valid(dir_consumed_valid), .dir_consumed_tag(dir_consumed_tag),
        .rdf_beat(rdf_beat), .rdf_last(rdf_last),
        .pending_cnt(pending_cnt), .consume_err(consume_err), .drain_err(drain_err)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic          error;
        logic [1:0]    resp;
        logic [7:0]    nb;
        logic          wr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input int tag, input int err, input int resp,
                                     input int nb, input int wr);
        exp_t e;
        e.tag = tag[TW-1:0]; e.error = err[0]; e.resp = resp[1:0];
        e.nb = nb[7:0]; e.wr = wr[0];
        exp_q.push_back(e);
    endfunction

    // Monitor: every new presentation is popped from the scoreboard and compared.
    always @(negedge pclk) begin
        exp_t e;
        if (preset) begin
            prev_valid = 1'b0;
        end else begin
            if (rd_status_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pres: got tag %0d expected no presentation", rd_status_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("pres_tag",   rd_status_tag,       e.tag);
                    chk("pres_err",   rd_status_error,     e.error);
                    chk("pres_resp",  rd_status_resp,      e.resp);
                    chk("pres_beats", rd_status_num_beats, e.nb);
                    chk("pres_wr",    rd_status_is_write,  e.wr);
                end
            end
            prev_valid = rd_status_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // One-cycle pulse of any combination of inputs; returns at the next negedge.
    task automatic pulse(input logic cv, input int ct, input int ce, input int cr,
                         input int cn, input int cw, input logic dv, input int dt,
                         input logic rb, input logic rl);
        cpl_valid = cv; cpl_tag = ct[TW-1:0]; cpl_error = ce[0]; cpl_resp = cr[1:0];
        cpl_num_beats = cn[7:0]; cpl_is_write = cw[0];
        dir_consumed_valid = dv; dir_consumed_tag = dt[TW-1:0];
        rdf_beat = rb; rdf_last = rl;
        @(negedge pclk);
        cpl_valid = 1'b0; dir_consumed_valid = 1'b0; rdf_beat = 1'b0; rdf_last = 1'b0;
    endtask

    task automatic cpl(input int tag, input int err, input int resp, input int nb, input int wr);
        pulse(1'b1, tag, err, resp, nb, wr, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic consume(input int tag);
        pulse(1'b0, 0, 0, 0, 0, 0, 1'b1, tag, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic last);
        pulse(1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b1, last);
    endtask

    task automatic wait_pres(input int tag, input string name);
        int k;
        k = 0;
        while (!(rd_status_valid && rd_status_tag == tag[TW-1:0]) && k < 64) begin
            @(negedge pclk);
            k++;
        end
        chk(name, int'(rd_status_valid && rd_status_tag == tag[TW-1:0]), 1);
    endtask

    task automatic do_reset();
        preset = 1'b1;
        exp_q.delete();
        tick(2);
        chk("rst_valid",   rd_status_valid, 0);
        chk("rst_tag",     rd_status_tag,   0);
        chk("rst_pending", pending_cnt,     0);
        chk("rst_cons",    consume_err,     0);
        chk("rst_drain",   drain_err,       0);
        preset = 1'b0;
        tick(1);
    endtask

    initial begin
        preset = 1'b1;
        cpl_valid = 1'b0; cpl_tag = '0; cpl_error = 1'b0; cpl_resp = 2'd0;
        cpl_num_beats = 8'd0; cpl_is_write = 1'b0;
        dir_consumed_valid = 1'b0; dir_consumed_tag = '0;
        rdf_beat = 1'b0; rdf_last = 1'b0;
        do_reset();

        // Single write: latency, pending count and no drain.
        push_exp(3, 0, 0, 0, 1);
        cpl(3, 0, 0, 0, 1);
        chk("w_lat_n", rd_status_valid, 0);
        tick(1);
        chk("w_lat_n1", rd_status_valid, 0);
        chk("w_pend1",  pending_cnt,     1);
        tick(1);
        chk("w_lat_n2", rd_status_valid, 1);
        chk("w_tag",    rd_status_tag,   3);
        consume(3);
        chk("w_drop", rd_status_valid, 0);
        tick(1);
        chk("w_pend0", pending_cnt, 0);
        tick(3);
        chk("w_idle", rd_status_valid, 0);

        // Read drain: tag 6 must wait for all four beats of tag 5.
        push_exp(5, 0, 0, 3, 0);
        push_exp(6, 0, 2, 0, 1);
        cpl(5, 0, 0, 3, 0);
        cpl(6, 0, 2, 0, 1);
        wait_pres(5, "rd_pres5");
        consume(5);
        for (int b = 0; b < 3; b++) begin
            beat(1'b0);
            tick(2);
            chk("rd_hold", rd_status_valid, 0);
        end
        beat(1'b1);
        chk("rd_after_last0", rd_status_valid, 0);
        tick(1);
        chk("rd_after_last1", rd_status_valid, 0);
        tick(1);
        chk("rd_next_valid", rd_status_valid, 1);
        chk("rd_next_tag",   rd_status_tag,   6);
        chk("rd_drain_ok",   drain_err,       0);
        consume(6);

        // Round-robin wrap: rr_ptr becomes 15 with tags 14, 15, 1 pending.
        push_exp(14, 0, 0, 0, 1);
        push_exp(15, 0, 0, 0, 1);
        push_exp(1,  0, 0, 0, 1);
        push_exp(14, 0, 1, 0, 1);
        cpl(14, 0, 0, 0, 1);
        wait_pres(14, "rr_pres14");
        cpl(15, 0, 0, 0, 1);
        cpl(1, 0, 0, 0, 1);
        pulse(1'b1, 14, 0, 1, 0, 1, 1'b1, 14, 1'b0, 1'b0);
        wait_pres(15, "rr_pres15");
        consume(15);
        wait_pres(1, "rr_pres1");
        consume(1);
        wait_pres(14, "rr_pres14b");
        chk("rr_new_resp", rd_status_resp, 1);
        consume(14);

        // Simultaneous set and consume on a read tag.
        push_exp(4, 0, 0, 0, 0);
        push_exp(4, 1, 3, 0, 1);
        cpl(4, 0, 0, 0, 0);
        wait_pres(4, "sim_pres4");
        pulse(1'b1, 4, 1, 3, 0, 1, 1'b1, 4, 1'b0, 1'b0);
        tick(1);
        chk("sim_pend",  pending_cnt,     1);
        chk("sim_valid", rd_status_valid, 0);
        beat(1'b1);
        wait_pres(4, "sim_repres");
        chk("sim_wr", rd_status_is_write, 1);
        consume(4);
        tick(1);
        chk("sim_pend0", pending_cnt, 0);

        // Wrong-tag consume and short-burst drain error.
        push_exp(2, 0, 0, 0, 1);
        cpl(2, 0, 0, 0, 1);
        wait_pres(2, "err_pres2");
        chk("err_cons0", consume_err, 0);
        consume(7);
        chk("err_cons1",  consume_err,     1);
        chk("err_keep_v", rd_status_valid, 1);
        chk("err_keep_t", rd_status_tag,   2);
        consume(2);
        push_exp(9, 0, 0, 1, 0);
        cpl(9, 0, 0, 1, 0);
        wait_pres(9, "err_pres9");
        consume(9);
        chk("err_drain0", drain_err, 0);
        beat(1'b1);
        chk("err_drain1", drain_err, 1);
        push_exp(10, 0, 0, 0, 1);
        cpl(10, 0, 0, 0, 1);
        tick(2);
        chk("err_idle_v", rd_status_valid, 1);
        chk("err_idle_t", rd_status_tag,   10);
        consume(10);

        // Reset mid-operation drops the table.
        cpl(11, 0, 0, 0, 1);
        cpl(12, 0, 0, 0, 1);
        do_reset();
        tick(3);
        chk("rst_lost_v", rd_status_valid, 0);
        chk("rst_lost_p", pending_cnt,     0);

        // Beat count reached without rdf_last.
        push_exp(0, 0, 0, 1, 0);
        push_exp(1, 0, 0, 0, 1);
        cpl(0, 0, 0, 1, 0);
        cpl(1, 0, 0, 0, 1);
        wait_pres(0, "ovr_pres0");
        consume(0);
        beat(1'b0);
        chk("ovr_drain0", drain_err,       0);
        chk("ovr_hold",   rd_status_valid, 0);
        beat(1'b0);
        chk("ovr_drain1", drain_err, 1);
        wait_pres(1, "ovr_pres1");
        consume(1);

`ifdef APB2AXI_CPL_TIMEOUT_EN
        // Drain watchdog with DRAIN_TMO = 16 and no beats.
        do_reset();
        push_exp(3, 0, 0, 0, 0);
        push_exp(4, 0, 0, 0, 1);
        cpl(3, 0, 0, 0, 0);
        cpl(4, 0, 0, 0, 1);
        wait_pres(3, "tmo_pres3");
        consume(3);
        tick(15);
        chk("tmo_drain0", drain_err, 0);
        tick(1);
        chk("tmo_drain1", drain_err, 1);
        wait_pres(4, "tmo_pres4");
        consume(4);
`endif

        tick(4);
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb2axi_cpl_sched.md
# apb2axi_cpl_sched

Completion scheduler between the response handler and the APB register gateway. It records each AXI completion in a per-tag table. It presents exactly one completion at a time on the gateway's RD_STATUS inputs, choosing among pending tags by round-robin. After software consumes a read completion, it holds off the next status until the RDF data stream for that tag has fully drained, so every RD_DATA burst belongs to the tag that was last shown.

## Interface
- TAG_W, default apb2axi_pkg::TAG_W (4): tag width; NUM_TAGS = 2**TAG_W table entries.
- DRAIN_TMO, default 1024: drain watchdog limit in cycles; used only with APB2AXI_CPL_TIMEOUT_EN.
- pclk  in  1  clock; the single clock of the block.
- preset  in  1  reset; asynchronous, active-high.
- cpl_valid  in  1  completion strobe from the response handler, one per cycle max.
- cpl_tag  in  TAG_W  completed tag.
- cpl_error  in  1  AXI error flag.
- cpl_resp  in  2  AXI BRESP or RRESP.
- cpl_num_beats  in  8  AXI len; beat count is num_beats+1. Ignored for writes.
- cpl_is_write  in  1  1 = write completion.
- rd_status_valid / rd_status_error / rd_status_resp[1:0] / rd_status_tag[TAG_W] / rd_status_num_beats[8] / rd_status_is_write  out  status currently presented to the gateway.
- dir_consumed_valid  in  1  SW consume pulse from the gateway.
- dir_consumed_tag  in  TAG_W  consumed tag.
- rdf_beat  in  1  one RD_DATA beat transferred (rdf_data_valid & rdf_data_ready).
- rdf_last  in  1  the transferred beat is the last beat.
- pending_cnt  out  TAG_W+1  number of table entries pending and not yet consumed.
- consume_err  out  1  sticky: consume arrived with the wrong tag, or while nothing was presented.
- drain_err  out  1  sticky: beat count and rdf_last disagreed, or drain watchdog expired.

## Operation
- Table: one pend bit plus one cpl_entry_t per tag.
  - cpl_valid sets pend[cpl_tag] and stores the entry at the edge.
  - cpl_valid on a tag that is already pending overwrites the entry; pend stays 1.
- FSM states: S_IDLE, S_LOAD, S_PRESENT, S_DRAIN.
- S_IDLE:
  - If any pend bit is set, round-robin pick from rr_ptr (inclusive, wrapping NUM_TAGS-1 → 0) and go to S_LOAD.
- S_LOAD:
  - Register the picked entry onto rd_status_*, assert rd_status_valid, go to S_PRESENT.
- S_PRESENT:
  - rd_status_* stay stable.
  - A consume with dir_consumed_tag == rd_status_tag does the following at that edge: clear pend[tag], set rr_ptr = tag+1 (mod NUM_TAGS), drop rd_status_valid.
  - After that consume, the next state is S_DRAIN for a read and S_IDLE for a write.
- S_DRAIN:
  - beat_cnt (9 bits) starts at 0 and increments on each rdf_beat.
  - Exit to S_IDLE on the beat with rdf_last.
  - If rdf_last arrives when beat_cnt+1 != num_beats+1, set drain_err and still exit.
  - If beat_cnt reaches num_beats+1 without rdf_last, set drain_err and exit.
- Any consume outside S_PRESENT, or with a mismatched tag, is ignored and sets consume_err.
- Simultaneous cpl_valid and matching consume on the same tag: the set wins. pend stays 1 with the new entry, and that tag becomes eligible again.
- pending_cnt is the registered popcount of pend.

## Timing
- Reset values:
  - state = S_IDLE, rr_ptr = 0, pend = 0, beat_cnt = 0.
  - All rd_status_* outputs = 0, pending_cnt = 0, consume_err = 0, drain_err = 0.
- Reset asserted mid-operation aborts immediately; the table is lost.
- Latency from cpl_valid (cycle N, table idle) to rd_status_valid high is cycle N+2.
- Latency from the consume edge to the next presentation:
  - write completion: 2 cycles (IDLE, then LOAD);
  - read completion: drain exit plus 2 cycles.
- rd_status_valid is low for at least 2 cycles between presentations, so the gateway never sees back-to-back status.
- pending_cnt lags pend by one cycle.

## Configuration
- APB2AXI_CPL_TIMEOUT_EN defined:
  - A tmo counter runs in S_DRAIN and resets on every rdf_beat.
  - Reaching DRAIN_TMO cycles without a beat sets drain_err and forces S_IDLE.
- Not defined: no counter; S_DRAIN waits indefinitely and DRAIN_TMO is unused.

## Structure
- apb2axi_pkg holds:
  - cpl_entry_t (error, resp, num_beats, is_write);
  - the cpl_sched_state_e enum;
  - the DRAIN_TMO default.
- TAG_W already lives in apb2axi_pkg.
- Sub-module apb2axi_rr_pick: combinational round-robin picker. It takes a NUM_TAGS request vector and a start pointer, and returns a found flag and the picked index.

## Test plan
- Single write: cpl tag 3, is_write=1, resp 0 at cycle N → rd_status_valid=1, tag=3, in cycle N+2. Consume tag 3 → valid low. pending_cnt goes 1 → 0. No drain.
- Read drain: cpl tag 5, num_beats=3. Consume, then 4 rdf_beat with last on the 4th → next status only after the 4th beat. drain_err=0.
- Round-robin wrap: pend tags 14, 15, 1 with rr_ptr=15 → presentation order 15, 1, 14.
- Errors: consume tag 7 while tag 2 is presented → consume_err=1, tag 2 stays presented. Read with num_beats=1 and rdf_last on beat 1 → drain_err=1, FSM back to S_IDLE.
- Simultaneous: cpl tag 4 in the same cycle as consume of presented tag 4 → pend[4]=1, and tag 4 is re-presented with the new entry.
- Timeout (APB2AXI_CPL_TIMEOUT_EN, DRAIN_TMO=16): read consumed, no beats → drain_err=1 after 16 cycles; the next pending tag is then presented.
